// File: rtl/stacked_regfile_pkg.sv
// Shared types and sizing helpers for the banked, level-stacked register file.
package stacked_regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int MAX_LW   = 8;

  typedef logic [MAX_LW-1:0] level_t;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_PUSH = 2'd1,
    LVL_POP  = 2'd2
  } level_op_e;

  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  function automatic int level_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stacked_regfile_level_ctrl.sv
// Context-level stack pointer: tracks the active bank level, full/empty state and
// sticky overflow/underflow, and strobes push_ok_o when a push really advances.
module stacked_regfile_level_ctrl
  import stacked_regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = level_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o,
  output logic          underflow_o,
  output logic          push_ok_o
);

  localparam logic [LW-1:0] TOP_LVL = LW'(DEPTH - 1);

  level_op_e     op_s;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          full_q;
  logic          empty_q;
  logic          overflow_q;
  logic          underflow_q;

  // Simultaneous push and pop is a tail-chained interrupt: treated as no change.
  always_comb begin
    op_s = LVL_HOLD;
    if (push_i && !pop_i) begin
      op_s = LVL_PUSH;
    end else if (pop_i && !push_i) begin
      op_s = LVL_POP;
    end else begin
      op_s = LVL_HOLD;
    end
  end

  always_comb begin
    level_d = level_q;
    case (op_s)
      LVL_PUSH: level_d = full_q  ? level_q : level_q + LW'(1);
      LVL_POP:  level_d = empty_q ? level_q : level_q - LW'(1);
      default:  level_d = level_q;
    endcase
  end

  assign push_ok_o = (op_s == LVL_PUSH) && !full_q;

  // Level register with full/empty precomputed from the next level.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q     <= '0;
      full_q      <= (DEPTH == 1);
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      level_q <= level_d;
      full_q  <= (level_d == TOP_LVL);
      empty_q <= (level_d == '0);
      if ((op_s == LVL_PUSH) && full_q) begin
        overflow_q <= 1'b1;
      end
      if ((op_s == LVL_POP) && empty_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign level_o     = level_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/stacked_regfile.sv
// Register file whose BANK_MASK-selected registers are replicated per context level;
// push/pop on interrupt entry/exit give handlers a fresh, zeroed bank.
module stacked_regfile
  import stacked_regfile_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NREGS     = 32,
  parameter int               NREAD     = 2,
  parameter int               DEPTH     = 4,
  parameter logic [NREGS-1:0] BANK_MASK = NREGS'(32'hFFFF_FFFE),
  parameter bit               BYPASS    = 1'b1,
  localparam int              AW        = addr_width(NREGS),
  localparam int              LW        = level_width(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NREAD*AW-1:0]    i_r_addr,
  output logic [NREAD*WIDTH-1:0] o_r_data,
  input  logic                   i_w_ena,
  input  logic [AW-1:0]          i_w_addr,
  input  logic [WIDTH-1:0]       i_w_data,
  input  logic                   i_push,
  input  logic                   i_pop,
  output logic [LW-1:0]          o_level,
  output logic                   o_full,
  output logic                   o_empty,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  logic [WIDTH-1:0] shared_q [NREGS];
  logic [WIDTH-1:0] bank_q   [DEPTH][NREGS];
  logic [LW-1:0]    level_s;
  logic [LW-1:0]    next_lvl_s;
  logic             push_ok_s;
  logic             wr_s;

  stacked_regfile_level_ctrl #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_level_ctrl (
    .clk_i       (i_clk),
    .rst_ni      (i_reset),
    .push_i      (i_push),
    .pop_i       (i_pop),
    .level_o     (level_s),
    .full_o      (o_full),
    .empty_o     (o_empty),
    .overflow_o  (o_overflow),
    .underflow_o (o_underflow),
    .push_ok_o   (push_ok_s)
  );

  assign o_level    = level_s;
  assign next_lvl_s = level_s + LW'(1);
  assign wr_s       = i_w_ena && (i_w_addr != AW'(REG_ZERO));

  // Write resolves against the pre-push level, so write+push lands in the old bank
  // while the freshly entered bank is zeroed on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int r = 0; r < NREGS; r++) begin
          bank_q[d][r] <= '0;
        end
      end
      for (int r = 0; r < NREGS; r++) begin
        shared_q[r] <= '0;
      end
    end else begin
      if (wr_s) begin
        if (BANK_MASK[i_w_addr]) begin
          bank_q[level_s][i_w_addr] <= i_w_data;
        end else begin
          shared_q[i_w_addr] <= i_w_data;
        end
      end
      if (push_ok_s) begin
        for (int r = 0; r < NREGS; r++) begin
          if (BANK_MASK[r]) begin
            bank_q[next_lvl_s][r] <= '0;
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    ra_s;
    logic [WIDTH-1:0] rd_s;

    assign ra_s = i_r_addr[k*AW +: AW];

    // Read mux: zero register, optional write forwarding, banked or shared storage.
    always_comb begin
      rd_s = '0;
      if (ra_s == AW'(REG_ZERO)) begin
        rd_s = '0;
      end else if (BYPASS && i_w_ena && (i_w_addr == ra_s)) begin
        rd_s = i_w_data;
      end else if (BANK_MASK[ra_s]) begin
        rd_s = bank_q[level_s][ra_s];
      end else begin
        rd_s = shared_q[ra_s];
      end
    end

    assign o_r_data[k*WIDTH +: WIDTH] = rd_s;
  end

endmodule

// File: tb/tb_stacked_regfile.sv
// Drives two stacked_regfile variants (full banking + bypass, partial banking without
// bypass) with directed and random traffic against a per-level array reference model.
module tb_stacked_regfile;

  localparam int DEPTH_C = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w_ena;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        push;
  logic        pop;
  logic [9:0]  raddr;

  logic [63:0] rd_o    [2];
  logic [1:0]  lvl_o   [2];
  logic        full_o  [2];
  logic        empty_o [2];
  logic        ovf_o   [2];
  logic        unf_o   [2];

  logic [31:0] mask_c   [2];
  bit          bypass_c [2];

  logic [31:0] m_sh  [2][32];
  logic [31:0] m_bk  [2][DEPTH_C][32];
  int          m_lvl [2];
  logic        m_ovf [2];
  logic        m_unf [2];

  int tests_run    = 0;
  int tests_failed = 0;
  bit armed        = 1'b0;

  always #5 clk = ~clk;

  stacked_regfile u_dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_r_addr(raddr), .o_r_data(rd_o[0]),
    .i_w_ena(w_ena), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_push(push), .i_pop(pop), .o_level(lvl_o[0]), .o_full(full_o[0]),
    .o_empty(empty_o[0]), .o_overflow(ovf_o[0]), .o_underflow(unf_o[0])
  );

  stacked_regfile #(.BANK_MASK(32'h0000_00F0), .BYPASS(1'b0)) u_dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_r_addr(raddr), .o_r_data(rd_o[1]),
    .i_w_ena(w_ena), .i_w_addr(w_addr), .i_w_data(w_data),
    .i_push(push), .i_pop(pop), .o_level(lvl_o[1]), .o_full(full_o[1]),
    .o_empty(empty_o[1]), .o_overflow(ovf_o[1]), .o_underflow(unf_o[1])
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int i, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bypass_c[i] && w_ena && (w_addr == a)) return w_data;
    if (mask_c[i][a]) return m_bk[i][m_lvl[i]][a];
    return m_sh[i][a];
  endfunction

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("dut%0d_rd%0d", i, k), 64'(rd_o[i][k*32 +: 32]),
            64'(model_read(i, raddr[k*5 +: 5])));
      end
      chk($sformatf("dut%0d_level", i), 64'(lvl_o[i]), 64'(m_lvl[i]));
      chk($sformatf("dut%0d_full", i), 64'(full_o[i]), 64'(m_lvl[i] == DEPTH_C - 1));
      chk($sformatf("dut%0d_empty", i), 64'(empty_o[i]), 64'(m_lvl[i] == 0));
      chk($sformatf("dut%0d_ovf", i), 64'(ovf_o[i]), 64'(m_ovf[i]));
      chk($sformatf("dut%0d_unf", i), 64'(unf_o[i]), 64'(m_unf[i]));
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic pu, input logic po,
                       input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    rst_n = r; w_ena = we; w_addr = wa; w_data = wd;
    push = pu; pop = po; raddr = {a1, a0};
    #1;
    if (armed) check_model();
  endtask

  task automatic idle(input logic [4:0] a0, input logic [4:0] a1);
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, a0, a1);
  endtask

  // Reference: a level counter plus one register array per level and one shared array.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        for (int r = 0; r < 32; r++) begin
          m_sh[i][r] = 32'd0;
          for (int d = 0; d < DEPTH_C; d++) m_bk[i][d][r] = 32'd0;
        end
        m_lvl[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
      end else begin
        if (w_ena && (w_addr != 5'd0)) begin
          if (mask_c[i][w_addr]) m_bk[i][m_lvl[i]][w_addr] = w_data;
          else m_sh[i][w_addr] = w_data;
        end
        if (push && !pop) begin
          if (m_lvl[i] == DEPTH_C - 1) m_ovf[i] = 1'b1;
          else begin
            m_lvl[i]++;
            for (int r = 0; r < 32; r++) m_bk[i][m_lvl[i]][r] = 32'd0;
          end
        end else if (pop && !push) begin
          if (m_lvl[i] == 0) m_unf[i] = 1'b1;
          else m_lvl[i]--;
        end
      end
    end
    armed = 1'b1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    tick();
  endtask

  initial begin
    mask_c[0] = 32'hFFFF_FFFE; bypass_c[0] = 1'b1;
    mask_c[1] = 32'h0000_00F0; bypass_c[1] = 1'b0;
    do_reset();
    do_reset();

    idle(5'd0, 5'd0);
    chk("rst_level", 64'(lvl_o[0]), 64'd0);
    chk("rst_empty", 64'(empty_o[0]), 64'd1);
    chk("rst_full", 64'(full_o[0]), 64'd0);
    tick();

    drive(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 5'd0); tick();
    idle(5'd5, 5'd0);
    chk("x5_read", rd_o[0], {32'd0, 32'hDEAD_BEEF});
    chk("x5_level", 64'(lvl_o[0]), 64'd0);
    tick();

    drive(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 1'b0, 5'd5, 5'd0); tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd5, 5'd0); tick();
    idle(5'd5, 5'd0);
    chk("push_x5_fresh", rd_o[0], 64'd0);
    chk("push_level", 64'(lvl_o[0]), 64'd1);
    tick();
    drive(1'b1, 1'b1, 5'd5, 32'h22, 1'b0, 1'b0, 5'd5, 5'd0); tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd0); tick();
    idle(5'd5, 5'd0);
    chk("pop_x5_a", rd_o[0], 64'h11);
    chk("pop_x5_b", rd_o[1], 64'h11);
    chk("pop_level", 64'(lvl_o[0]), 64'd0);
    tick();

    drive(1'b1, 1'b1, 5'd1, 32'hA5, 1'b0, 1'b0, 5'd1, 5'd4); tick();
    drive(1'b1, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd1, 5'd4); tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd1, 5'd4); tick();
    idle(5'd1, 5'd4);
    chk("mask_b_shared_x1", rd_o[1], {32'd0, 32'hA5});
    chk("mask_a_banked_x1", rd_o[0], 64'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd1, 5'd4); tick();

    do_reset();
    for (int n = 1; n <= 4; n++) begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
      idle(5'd0, 5'd0);
      chk($sformatf("push%0d_level", n), 64'(lvl_o[0]), 64'((n > 3) ? 3 : n));
      chk($sformatf("push%0d_full", n), 64'(full_o[0]), 64'(n >= 3));
      chk($sformatf("push%0d_ovf", n), 64'(ovf_o[0]), 64'(n == 4));
    end
    for (int n = 1; n <= 4; n++) begin
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd0, 5'd0); tick();
      idle(5'd0, 5'd0);
      chk($sformatf("pop%0d_level", n), 64'(lvl_o[0]), 64'((n > 3) ? 0 : 3 - n));
      chk($sformatf("pop%0d_empty", n), 64'(empty_o[0]), 64'(n >= 3));
      chk($sformatf("pop%0d_unf", n), 64'(unf_o[0]), 64'(n == 4));
      chk($sformatf("pop%0d_ovf_sticky", n), 64'(ovf_o[0]), 64'd1);
    end

    do_reset();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0, 5'd9, 5'd0); tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd9, 5'd0); tick();
    idle(5'd9, 5'd0);
    chk("tail_level", 64'(lvl_o[0]), 64'd2);
    chk("tail_x9_kept", rd_o[0], 64'h99);
    tick();
    drive(1'b1, 1'b1, 5'd10, 32'hAB, 1'b1, 1'b0, 5'd10, 5'd0); tick();
    idle(5'd10, 5'd0);
    chk("wpush_new_clear", rd_o[0], 64'd0);
    chk("wpush_level", 64'(lvl_o[0]), 64'd3);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd10, 5'd9); tick();
    idle(5'd10, 5'd9);
    chk("wpush_old_holds", rd_o[0], {32'h99, 32'hAB});
    tick();

    do_reset();
    drive(1'b1, 1'b1, 5'd7, 32'h55, 1'b0, 1'b0, 5'd7, 5'd0);
    chk("bypass_on", rd_o[0], 64'h55);
    chk("bypass_off", rd_o[1], 64'd0);
    tick();
    idle(5'd7, 5'd0);
    chk("bypass_off_after", rd_o[1], 64'h55);
    tick();

    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 5'd0); tick();
    drive(1'b1, 1'b1, 5'd3, 32'h33, 1'b0, 1'b0, 5'd3, 5'd7); tick();
    drive(1'b0, 1'b1, 5'd4, 32'h77, 1'b1, 1'b0, 5'd3, 5'd7); tick();
    idle(5'd3, 5'd7);
    chk("midrst_level", 64'(lvl_o[0]), 64'd0);
    chk("midrst_data_a", rd_o[0], 64'd0);
    chk("midrst_data_b", rd_o[1], 64'd0);
    tick();

    for (int c = 0; c < 2000; c++) begin
      logic [4:0]  wa;
      logic [4:0]  a0;
      logic [4:0]  a1;
      wa = 5'($urandom_range(0, 31));
      a0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), wa, $urandom(),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3), a0, a1);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
